// File: rtl/gcd_seq.sv
// Clocked GCD engine with four-phase activate/x/y/z channels, one algorithm step per cycle.
// Define GCD_STEIN_EN to replace the subtractive step with the binary (Stein) step.
module gcd_seq #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         initialise_n,
  input  logic         activate_0r,
  output logic         activate_0a,
  output logic         x_0r,
  input  logic         x_0a,
  input  logic [W-1:0] x_0d,
  output logic         y_0r,
  input  logic         y_0a,
  input  logic [W-1:0] y_0d,
  output logic         z_0r,
  input  logic         z_0a,
  output logic [W-1:0] z_0d
);

  // state   | meaning
  // IDLE    | waiting for activate_0r
  // FETCH   | x_0r/y_0r high, latching operands as acks arrive
  // RTZ_IN  | requests dropped, waiting for both operand acks low
  // CALC    | one gcd step per cycle until a terminating condition
  // OUT     | z_0r high with result on z_0d
  // RTZ_OUT | waiting for z_0a low
  // DONE    | activate_0a high, waiting for activate_0r low
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_RTZ_IN, S_CALC, S_OUT, S_RTZ_OUT, S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [W-1:0] a, b, a_step, b_step, result;
  logic         x_got, y_got;
  logic         fetch_done, calc_done;

`ifdef GCD_STEIN_EN
  localparam int KW = $clog2(W) + 1;
  logic [KW-1:0] k, k_step;
`endif

  assign fetch_done = (x_got | x_0a) & (y_got | y_0a);
  assign calc_done  = (a == '0) || (b == '0) || (a == b);

  always_ff @(posedge clk or negedge initialise_n) begin
    if (!initialise_n) state <= S_IDLE;
    else               state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (activate_0r)     state_nxt = S_FETCH;
      S_FETCH:   if (fetch_done)      state_nxt = S_RTZ_IN;
      S_RTZ_IN:  if (!x_0a && !y_0a)  state_nxt = S_CALC;
      S_CALC:    if (calc_done)       state_nxt = S_OUT;
      S_OUT:     if (z_0a)            state_nxt = S_RTZ_OUT;
      S_RTZ_OUT: if (!z_0a)           state_nxt = S_DONE;
      S_DONE:    if (!activate_0r)    state_nxt = S_IDLE;
      default:                        state_nxt = S_IDLE;
    endcase
  end

  // Outputs decode straight from the state register, so no input reaches an output combinationally.
  always_comb begin
    x_0r        = (state == S_FETCH);
    y_0r        = (state == S_FETCH);
    z_0r        = (state == S_OUT);
    activate_0a = (state == S_DONE);
  end

`ifdef GCD_STEIN_EN
  always_comb begin
    a_step = a;
    b_step = b;
    k_step = k;
    if (!a[0] && !b[0]) begin
      a_step = a >> 1;
      b_step = b >> 1;
      k_step = k + KW'(1);
    end else if (!a[0]) begin
      a_step = a >> 1;
    end else if (!b[0]) begin
      b_step = b >> 1;
    end else if (a > b) begin
      a_step = (a - b) >> 1;
    end else begin
      b_step = (b - a) >> 1;
    end
    result = ((a == '0) ? b : a) << k;
  end
`else
  always_comb begin
    a_step = a;
    b_step = b;
    if (a > b) a_step = a - b;
    else       b_step = b - a;
    result = (a == '0) ? b : a;
  end
`endif

  always_ff @(posedge clk or negedge initialise_n) begin
    if (!initialise_n) begin
      a     <= '0;
      b     <= '0;
      z_0d  <= '0;
      x_got <= 1'b0;
      y_got <= 1'b0;
`ifdef GCD_STEIN_EN
      k     <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          x_got <= 1'b0;
          y_got <= 1'b0;
        end
        S_FETCH: begin
          if (x_0a && !x_got) begin
            a     <= x_0d;
            x_got <= 1'b1;
          end
          if (y_0a && !y_got) begin
            b     <= y_0d;
            y_got <= 1'b1;
          end
        end
`ifdef GCD_STEIN_EN
        S_RTZ_IN: if (!x_0a && !y_0a) k <= '0;
`endif
        S_CALC: begin
          if (calc_done) begin
            z_0d <= result;
          end else begin
            a <= a_step;
            b <= b_step;
`ifdef GCD_STEIN_EN
            k <= k_step;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_seq.sv
// Randomised bench for gcd_seq: drives all four channels and checks results and CALC latency
// against an Euclid-based reference (gcd and subtraction count from division quotients).
module tb_gcd_seq;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         initialise_n = 1'b0;
  logic         activate_0r = 1'b0;
  logic         activate_0a;
  logic         x_0r, y_0r, z_0r;
  logic         x_0a = 1'b0, y_0a = 1'b0, z_0a = 1'b0;
  logic [W-1:0] x_0d = '0, y_0d = '0;
  logic [W-1:0] z_0d;

  int n_chk  = 0;
  int n_pass = 0;

  gcd_seq #(.W(W)) dut (
    .clk(clk), .initialise_n(initialise_n),
    .activate_0r(activate_0r), .activate_0a(activate_0a),
    .x_0r(x_0r), .x_0a(x_0a), .x_0d(x_0d),
    .y_0r(y_0r), .y_0a(y_0a), .y_0d(y_0d),
    .z_0r(z_0r), .z_0a(z_0a), .z_0d(z_0d)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, longint got, longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int ref_gcd(int a, int b);
    int t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // Subtractive step count is the sum of Euclid quotients minus one; CALC adds the terminating cycle.
  function automatic int ref_calc(int a, int b);
    int q = 0, t;
    if (a == 0 || b == 0) return 1;
    while (b != 0) begin
      q += a / b;
      t = a % b;
      a = b;
      b = t;
    end
    return q;
  endfunction

  function automatic logic sig(int sel);
    case (sel)
      0:       return x_0r;
      1:       return z_0r;
      default: return activate_0a;
    endcase
  endfunction

  task automatic wait_for(string tag, int sel, logic val, int budget);
    int n = 0;
    while (sig(sel) !== val && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, sig(sel) === val, 1);
  endtask

  task automatic fetch(int x, int y, int xd, int yd);
    int c = 0;
    activate_0r = 1'b1;
    wait_for("x_req_rise", 0, 1'b1, 8);
    while ((x_0r || y_0r) && c < 40) begin
      if (c >= xd) begin x_0a = 1'b1; x_0d = W'(x); end
      else x_0d = W'($urandom);
      if (c >= yd) begin y_0a = 1'b1; y_0d = W'(y); end
      else y_0d = W'($urandom);
      @(negedge clk);
      c++;
    end
    chk("fetch_close", x_0r | y_0r, 0);
    x_0a = 1'b0;
    y_0a = 1'b0;
    x_0d = W'($urandom);
    y_0d = W'($urandom);
  endtask

  task automatic run_txn(string tag, int x, int y, int xd, int yd, int zd);
    int cnt = 0;
    int exp_z = ref_gcd(x, y);
    logic stable = 1'b1;
    fetch(x, y, xd, yd);
    do begin
      @(negedge clk);
      cnt++;
    end while (!z_0r && cnt < 600);
    chk({tag, "_zreq"}, z_0r, 1);
    chk({tag, "_z"}, z_0d, exp_z);
`ifdef GCD_STEIN_EN
    chk({tag, "_calc_bound"}, (cnt - 1) <= 2 * W + 1, 1);
`else
    chk({tag, "_calc"}, cnt - 1, ref_calc(x, y));
`endif
    for (int i = 0; i < zd; i++) begin
      @(negedge clk);
      if (z_0d !== W'(exp_z) || !z_0r) stable = 1'b0;
    end
    z_0a = 1'b1;
    wait_for("z_req_fall", 1, 1'b0, 8);
    if (z_0d !== W'(exp_z)) stable = 1'b0;
    z_0a = 1'b0;
    wait_for("act_ack_rise", 2, 1'b1, 8);
    if (z_0d !== W'(exp_z)) stable = 1'b0;
    chk({tag, "_z_stable"}, stable, 1);
    activate_0r = 1'b0;
    wait_for("act_ack_fall", 2, 1'b0, 8);
  endtask

  initial begin
    int x, y;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {activate_0a, x_0r, y_0r, z_0r, z_0d}, 0);
    initialise_n = 1'b1;
    @(negedge clk);

    run_txn("t13_5", 13, 5, 1, 1, 1);
    run_txn("t12_16", 12, 16, 1, 1, 1);
    run_txn("t0_9", 0, 9, 1, 1, 1);
    run_txn("t9_0", 9, 0, 1, 1, 1);
    run_txn("t0_0", 0, 0, 1, 1, 1);
    run_txn("t255_1", 255, 1, 1, 1, 1);
    run_txn("tskew", 36, 84, 0, 3, 5);
    run_txn("tskew_y", 100, 75, 2, 0, 0);
    run_txn("tequal", 77, 77, 0, 0, 2);

    fetch(255, 1, 1, 1);
    repeat (10) @(negedge clk);
    chk("mid_calc_no_zreq", z_0r, 0);
    initialise_n = 1'b0;
    #1;
    chk("abort_outputs", {activate_0a, x_0r, y_0r, z_0r, z_0d}, 0);
    activate_0r = 1'b0;
    @(negedge clk);
    initialise_n = 1'b1;
    @(negedge clk);
    run_txn("after_abort", 16, 12, 1, 1, 1);

    for (int i = 0; i < 25; i++) begin
      x = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 255));
      y = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 255));
      run_txn("rand", x, y, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
